// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the window packer and the adder tree it feeds.
// Holds the default window geometry, the Q16.16 / Q22.16 fixed-point types
// and the packer state encoding.
package adder_tree_pkg;

  // Default window geometry: 49 Q16.16 words, summed into a Q22.16 result.
  localparam int N_TAPS = 49;
  localparam int DATA_W = 32;
  localparam int SUM_W  = 38;

  // Word counter width; must be able to hold N_TAPS-1.
  localparam int CNT_W  = 6;

  // Signed fixed-point views of one input word and of the full window sum.
  typedef logic signed [DATA_W-1:0] q16_16_t;
  typedef logic signed [SUM_W-1:0]  q22_16_t;

  // FILL collects words; HOLD presents a complete window downstream.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : adder_tree_pkg

// File: rtl/packer_accum.sv
// Running sum of accepted window words.
// Each word is sign-extended from DATA_W to SUM_W bits before it is added,
// so the sum of 49 full-scale Q16.16 words cannot overflow. clr restarts
// the sum for a new window; rst has the same effect.
module packer_accum
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SUM_W  = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum
);

  logic [SUM_W-1:0] sum_reg;
  logic [SUM_W-1:0] data_ext;

  // Sign-extend the incoming word to the accumulator width.
  assign data_ext = {{(SUM_W - DATA_W){data[DATA_W-1]}}, data};

  // Accumulate accepted words; restart on reset or window restart.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_reg <= '0;
    end else if (add_en) begin
      sum_reg <= sum_reg + data_ext;
    end
  end

  assign sum = sum_reg;

endmodule : packer_accum

// File: rtl/window_packer_49.sv
// Serial-to-parallel window packer for the 49-input adder tree.
// Collects N_TAPS Q16.16 words from a valid/ready stream into a flat vector
// and presents it with out_valid until the consumer acknowledges it.
// Optional feature: define PACKER_REF_SUM_EN to add a ref_sum output that
// carries the exact Q22.16 sum of the held window (for cross-checking the
// adder tree).
module window_packer_49
  import adder_tree_pkg::*;
#(
  parameter int N_TAPS = 49,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic [N_TAPS*DATA_W-1:0] in_flat,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef PACKER_REF_SUM_EN
  ,
  output logic [SUM_W-1:0]         ref_sum
`endif
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  logic             s_ready_reg;

  logic accept;
  logic last_word;
  logic hold_done;

  // A word is taken only while filling and never in a clearing cycle.
  assign accept    = s_valid && s_ready_reg && !clear && (state_reg == ST_FILL);
  assign last_word = (cnt_reg == CNT_W'(N_TAPS - 1));
  assign hold_done = (state_reg == ST_HOLD) && out_valid_reg && out_ready;

  // Window sequencing: FILL counts accepted words, HOLD waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      s_ready_reg   <= 1'b1;
    end else if (clear) begin
      state_reg     <= ST_FILL;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      s_ready_reg   <= 1'b1;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            if (last_word) begin
              cnt_reg       <= '0;
              state_reg     <= ST_HOLD;
              out_valid_reg <= 1'b1;
              s_ready_reg   <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_reg     <= ST_FILL;
            out_valid_reg <= 1'b0;
            s_ready_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_FILL;
          cnt_reg       <= '0;
          out_valid_reg <= 1'b0;
          s_ready_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign s_ready   = s_ready_reg;

  // One register per slot. Slots keep their previous contents until the
  // new window overwrites them; out_valid is what qualifies in_flat.
  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_reg;

    // Capture the accepted word into the slot addressed by the counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_reg <= '0;
      end else if (accept && (cnt_reg == CNT_W'(gi))) begin
        slot_reg <= s_data;
      end
    end

    assign in_flat[gi*DATA_W +: DATA_W] = slot_reg;
  end

`ifdef PACKER_REF_SUM_EN
  logic accum_clr;

  // Restart the running sum on clear and when a held window is handed off.
  assign accum_clr = clear || hold_done;

  packer_accum #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (accum_clr),
    .add_en (accept),
    .data   (s_data),
    .sum    (ref_sum)
  );
`endif

endmodule : window_packer_49

// File: doc/window_packer_49.md
WINDOW_PACKER_49 -- requirements
Module: window_packer_49

Interface
REQ-001 SHALL have parameter N_TAPS, default 49, number of Q16.16 words per window.
REQ-002 SHALL have parameter DATA_W, default 32, width of one Q16.16 word.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port clear, input, 1, discard partial/held window.
REQ-006 SHALL have port s_valid, input, 1, serial word valid.
REQ-007 SHALL have port s_ready, output, 1, packer can accept a word.
REQ-008 SHALL have port s_data, input, DATA_W, signed Q16.16 word.
REQ-009 SHALL have port in_flat, output, N_TAPS*DATA_W, packed window, word k at [k*DATA_W +: DATA_W]; feeds the 49-input adder tree.
REQ-010 SHALL have port out_valid, input-facing handshake output, 1, in_flat holds a complete window.
REQ-011 SHALL have port out_ready, input, 1, consumer has taken the window.
REQ-012 SHALL have port ref_sum, output, 38, signed Q22.16 sum of the held window (present only with the macro in REQ-027).

Function
REQ-013 SHALL implement two states: FILL (collecting words) and HOLD (window presented).
REQ-014 In FILL, s_ready SHALL be 1 and out_valid 0; in HOLD, s_ready SHALL be 0 and out_valid 1; both SHALL be registered.
REQ-015 A word is accepted when s_valid and s_ready are both 1 and clear is 0; word number k (0-based, within the window) SHALL be written to slot k.
REQ-016 A 6-bit counter SHALL track accepted words; on acceptance of word N_TAPS-1, the counter SHALL return to 0 and the state SHALL go to HOLD on the next edge.
REQ-017 out_valid SHALL rise on the cycle after the 49th word is accepted (latency 1 cycle).
REQ-018 In HOLD, in_flat SHALL remain stable until out_valid and out_ready are both 1; the state SHALL then return to FILL on the next edge.
REQ-019 A transfer with out_ready already high SHALL complete in one HOLD cycle; the minimum window period SHALL be 50 cycles.
REQ-020 clear SHALL take priority over everything else: it forces FILL with the counter at 0 and out_valid 0, and a word presented in the same cycle SHALL be dropped.
REQ-021 Slots not yet overwritten in a new window SHALL keep their old values; only out_valid qualifies in_flat.
REQ-022 s_valid in HOLD SHALL be ignored (back-pressure); the source holds its word until s_ready returns.

Reset
REQ-023 On rst=1 the module SHALL set state=FILL, counter=0, out_valid=0, s_ready=1 at the next edge.
REQ-024 On rst=1 the module SHALL set in_flat to all zeros and ref_sum to 0.
REQ-025 rst mid-window or in HOLD SHALL discard the window; no out_valid SHALL appear for it.
REQ-026 rst SHALL take priority over clear.

Configuration
REQ-027 With macro PACKER_REF_SUM_EN defined, the module SHALL accumulate the accepted words sign-extended to 38 bits; ref_sum SHALL equal the exact sum of the held window while out_valid=1, and the accumulator SHALL be zeroed on rst, clear and FILL restart.
REQ-028 Without PACKER_REF_SUM_EN, the module SHALL have no ref_sum port and no accumulator logic.

Structure
REQ-029 Package adder_tree_pkg SHALL hold N_TAPS=49, DATA_W=32, SUM_W=38, typedefs q16_16_t (signed 32) and q22_16_t (signed 38), and the state enum.
REQ-030 The accumulator SHALL be one sub-module, packer_accum, instantiated only under PACKER_REF_SUM_EN.

Verification
REQ-031 49 words of 65536 sent back-to-back with out_ready=1 -> out_valid at cycle 50, all slots 65536, ref_sum=49*65536 (49.0).
REQ-032 49 words of 32768 with out_ready=0 for 10 cycles -> out_valid held, s_ready=0, in_flat stable, ref_sum=24.5; handshake then returns to FILL.
REQ-033 Words 65536, 32768, -65536, 98304, -32768 followed by 44 zeros -> slots 0-4 as sent, ref_sum=98304 (1.5).
REQ-034 clear asserted after 20 words, with s_valid high in the same cycle -> that word is dropped; the next 49 words form the window, and out_valid appears only after those 49.
REQ-035 rst pulsed in HOLD -> out_valid=0 and in_flat=0 next cycle; a fresh 49-word window then completes normally.
REQ-036 Random s_valid gaps -> the words are packed in order, with no loss or duplication.
